// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: parity modes, transmitter FSM states
// and a constant clog2 helper usable in port widths.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } tx_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with async active-high reset; full/empty come from read and
// write pointers carrying one extra wrap bit. Head data is read combinationally.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_wr_data,
  input  logic                  i_pop,
  output logic [WIDTH-1:0]      o_rd_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [clog2(DEPTH):0] o_count
);

  localparam int AW = clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  // A push against a full FIFO is dropped even if a pop frees a slot this cycle.
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; entries are only ever
  // read between the pointers, and a reset-free array can map onto RAM.
  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count   = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a write FIFO: start, DATA_BITS payload (LSB first),
// optional parity and STOP_BITS stop bits, each bit held CLK_DIV clocks.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CLK_DIV    = 16,
  parameter int PARITY     = PAR_NONE,
  parameter int STOP_BITS  = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [DATA_BITS-1:0]       wr_data,
  input  logic                       clear_overflow,
  output logic                       full,
  output logic [clog2(FIFO_DEPTH):0] count,
  output logic                       busy,
  output logic                       overflow,
  output logic                       tx
);

  localparam int BW = clog2(CLK_DIV);
  localparam int IW = clog2(DATA_BITS) + 1;

  tx_state_e            r_state,   w_state_next;
  logic [BW-1:0]        r_bit_cnt, w_bit_cnt_next;
  logic [IW-1:0]        r_idx,     w_idx_next;
  logic [DATA_BITS-1:0] r_shift,   w_shift_next;
  logic                 r_par,     w_par_next;
  logic                 r_tx,      w_tx_next;
  logic                 r_overflow;
  logic                 w_pop;
  logic                 w_empty;
  logic                 w_bit_end;
  logic [DATA_BITS-1:0] w_head;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .i_push    (wr_en),
    .i_wr_data (wr_data),
    .i_pop     (w_pop),
    .o_rd_data (w_head),
    .o_full    (full),
    .o_empty   (w_empty),
    .o_count   (count)
  );

  assign w_bit_end = (r_bit_cnt == BW'(CLK_DIV - 1));

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    w_state_next   = r_state;
    w_bit_cnt_next = r_bit_cnt;
    w_idx_next     = r_idx;
    w_shift_next   = r_shift;
    w_par_next     = r_par;
    w_pop          = 1'b0;
    w_tx_next      = 1'b1;

    if (r_state != IDLE) w_bit_cnt_next = w_bit_end ? '0 : r_bit_cnt + 1'b1;

    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_shift_next = w_head;
          w_par_next   = (^w_head) ^ (PARITY == PAR_ODD);
          w_state_next = START;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_idx_next   = '0;
          w_state_next = DATA;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_shift_next = r_shift >> 1;
          if (r_idx == IW'(DATA_BITS - 1)) begin
            w_idx_next   = '0;
            w_state_next = (PARITY != PAR_NONE) ? PAR : STOP;
          end else begin
            w_idx_next = r_idx + 1'b1;
          end
        end
      end
      PAR: begin
        if (w_bit_end) begin
          w_idx_next   = '0;
          w_state_next = STOP;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          if (r_idx == IW'(STOP_BITS - 1)) begin
            w_idx_next = '0;
            // Back-to-back frames: reload straight into START without idling.
            if (!w_empty) begin
              w_pop        = 1'b1;
              w_shift_next = w_head;
              w_par_next   = (^w_head) ^ (PARITY == PAR_ODD);
              w_state_next = START;
            end else begin
              w_state_next = IDLE;
            end
          end else begin
            w_idx_next = r_idx + 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase

    case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_shift_next[0];
      PAR:     w_tx_next = w_par_next;
      default: w_tx_next = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the clock edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_idx     <= w_idx_next;
      r_shift   <= w_shift_next;
      r_par     <= w_par_next;
      r_tx      <= w_tx_next;
    end
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                 r_overflow <= 1'b0;
    else if (wr_en && full)    r_overflow <= 1'b1;
    else if (clear_overflow)   r_overflow <= 1'b0;
  end

  assign tx       = r_tx;
  assign busy     = (r_state != IDLE);
  assign overflow = r_overflow;

endmodule
